// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter - round-robin req/ack arbiter sharing one synchronous RAM port
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              halt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              idle,
  output logic              gnt_b
);

  localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_b_q, gnt_b_d;
  logic                last_b_q, last_b_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                idle_q, idle_d;
  logic                win_b;

  // The RAM strobe registers double as the latched request: ISSUE always
  // follows the grant cycle directly, so they hold the winner's we/addr/wdata.
  always_comb begin
    state_d     = state_q;
    gnt_b_d     = gnt_b_q;
    last_b_d    = last_b_q;
    cnt_d       = cnt_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    idle_d      = 1'b0;
    win_b       = (a_req && b_req) ? ~last_b_q : b_req;

    case (state_q)
      ST_IDLE: begin
        if (!halt && (a_req || b_req)) begin
          state_d     = ST_ISSUE;
          gnt_b_d     = win_b;
          last_b_d    = win_b;
          ram_en_d    = 1'b1;
          ram_we_d    = win_b ? b_we : a_we;
          ram_addr_d  = win_b ? b_addr : a_addr;
          ram_wdata_d = win_b ? b_wdata : a_wdata;
        end else begin
          idle_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (ram_we_q) begin
          state_d = ST_RESP;
          a_ack_d = ~gnt_b_q;
          b_ack_d = gnt_b_q;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = RD_LAT_CNT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_RESP;
          a_ack_d = ~gnt_b_q;
          b_ack_d = gnt_b_q;
          if (gnt_b_q) b_rdata_d = ram_rdata;
          else         a_rdata_d = ram_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idle_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      cnt_q       <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_b_q     <= gnt_b_d;
      last_b_q    <= last_b_d;
      cnt_q       <= cnt_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      idle_q      <= idle_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign idle      = idle_q;
  assign gnt_b     = gnt_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter - vectors, ack scoreboard and corner sequences (RD_LAT 1 and 3)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, halt = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ack, b_ack, ram_en, ram_we, idle, gnt_b;
  logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  logic          x_b_req = 1'b0, x_zero = 1'b0;
  logic [AW-1:0] x_b_addr = '0, x_zaddr = '0;
  logic [DW-1:0] x_zdata = '0;
  logic          x_a_ack, x_b_ack, x_ram_en, x_ram_we, x_idle, x_gnt_b;
  logic [DW-1:0] x_a_rdata, x_b_rdata, x_ram_wdata, x_ram_rdata;
  logic [AW-1:0] x_ram_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u1 (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .halt(halt), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .idle(idle), .gnt_b(gnt_b));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u3 (
    .clk(clk), .clr(clr),
    .a_req(x_zero), .a_we(x_zero), .a_addr(x_zaddr), .a_wdata(x_zdata), .a_ack(x_a_ack), .a_rdata(x_a_rdata),
    .b_req(x_b_req), .b_we(x_zero), .b_addr(x_b_addr), .b_wdata(x_zdata), .b_ack(x_b_ack), .b_rdata(x_b_rdata),
    .halt(x_zero), .ram_en(x_ram_en), .ram_we(x_ram_we), .ram_addr(x_ram_addr), .ram_wdata(x_ram_wdata),
    .ram_rdata(x_ram_rdata), .idle(x_idle), .gnt_b(x_gnt_b));

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 9'h1FF) ? 32'h1234_5678 : (32'h5A00_0000 | 32'(a));
  endfunction

  // RAM models: unwritten words read back init_val; idle read bus carries junk
  logic [DW-1:0] mem1 [0:511];
  logic [DW-1:0] mem3 [0:511];
  bit   [511:0]  wr1, wr3;
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem1[ram_addr] <= ram_wdata;
      wr1[ram_addr]  <= 1'b1;
    end
    pipe1 <= (ram_en && !ram_we) ? (wr1[ram_addr] ? mem1[ram_addr] : init_val(ram_addr)) : 32'hBAD0_0001;
  end
  assign ram_rdata = pipe1;

  always @(posedge clk) begin
    if (x_ram_en && x_ram_we) begin
      mem3[x_ram_addr] <= x_ram_wdata;
      wr3[x_ram_addr]  <= 1'b1;
    end
    pipe3[0] <= (x_ram_en && !x_ram_we) ? (wr3[x_ram_addr] ? mem3[x_ram_addr] : init_val(x_ram_addr)) : 32'hBAD0_0003;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign x_ram_rdata = pipe3[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          port_b;
    logic          is_rd;
    logic [DW-1:0] rdata;
  } sb_t;
  sb_t sbq[$];
  sb_t sb_e;

  always @(negedge clk) begin
    if (clr && (a_ack || b_ack)) begin
      check("ack_onehot", 32'(a_ack & b_ack), 32'd0);
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: a_ack=%b b_ack=%b, no transaction outstanding", a_ack, b_ack);
      end else begin
        sb_e = sbq.pop_front();
        check("ack_port", 32'(b_ack), 32'(sb_e.port_b));
        if (sb_e.is_rd) check("ack_rdata", sb_e.port_b ? b_rdata : a_rdata, sb_e.rdata);
      end
    end
  end

  task automatic push_exp(input logic pb, input logic rd, input logic [DW-1:0] rdv);
    sb_t e;
    e.port_b = pb;
    e.is_rd  = rd;
    e.rdata  = rdv;
    sbq.push_back(e);
  endtask

  task automatic do_txn(input logic pb, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                        input int exp_cyc, input string tag);
    int n;
    int en_cnt;
    logic [DW-1:0] other;
    @(negedge clk);
    other = pb ? a_rdata : b_rdata;
    push_exp(pb, !we, exp_rd);
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    n = 0;
    en_cnt = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ram_en) begin
        en_cnt++;
        check({tag, "_ram_we"}, 32'(ram_we), 32'(we));
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr));
        if (we) check({tag, "_ram_wdata"}, ram_wdata, wd);
        check({tag, "_gnt_b"}, 32'(gnt_b), 32'(pb));
      end
      if (pb ? b_ack : a_ack) break;
    end
    check({tag, "_ack_cycle"}, 32'(n + 1), 32'(exp_cyc));
    check({tag, "_ram_en_cycles"}, 32'(en_cnt), 32'd1);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    check({tag, "_other_rdata"}, pb ? a_rdata : b_rdata, other);
  endtask

  typedef struct {
    logic          pb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
    int            exp_cyc;
    string         tag;
  } vec_t;
  vec_t vt [6];

  initial begin : main
    int n;
    int acks;
    int grants;
    logic prev_ack;
    logic any_ack;

    vt[0] = '{1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF, 32'h0,         3, "a_wr_005"};
    vt[1] = '{1'b1, 1'b0, 9'h1FF, 32'h0,         32'h1234_5678, 4, "b_rd_1ff"};
    vt[2] = '{1'b0, 1'b0, 9'h005, 32'h0,         32'hDEAD_BEEF, 4, "a_rd_005"};
    vt[3] = '{1'b1, 1'b1, 9'h100, 32'hCAFE_F00D, 32'h0,         3, "b_wr_100"};
    vt[4] = '{1'b0, 1'b0, 9'h100, 32'h0,         32'hCAFE_F00D, 4, "a_rd_100"};
    vt[5] = '{1'b1, 1'b0, 9'h000, 32'h0,         init_val(9'h000), 4, "b_rd_000"};

    repeat (3) @(posedge clk);
    #2;
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_gnt_b", 32'(gnt_b), 32'd0);

    for (int i = 0; i < 6; i++)
      do_txn(vt[i].pb, vt[i].we, vt[i].addr, vt[i].wd, vt[i].exp_rd, vt[i].exp_cyc, vt[i].tag);

    // B read on the RD_LAT=3 instance
    @(negedge clk);
    x_b_req = 1'b1;
    x_b_addr = 9'h1FF;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (x_b_ack) break;
    end
    x_b_req = 1'b0;
    check("lat3_ack_cycle", 32'(n + 1), 32'd6);
    check("lat3_b_rdata", x_b_rdata, 32'h1234_5678);
    check("lat3_a_rdata", x_a_rdata, 32'd0);
    check("lat3_a_ack", 32'(x_a_ack), 32'd0);
    check("lat3_gnt_b", 32'(x_gnt_b), 32'd1);

    // Contention: both held high, last grant was B
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0, 32'h0);
    a_we = 1'b1; a_addr = 9'h010; a_wdata = 32'hAAAA_0001;
    b_we = 1'b1; b_addr = 9'h020; b_wdata = 32'hBBBB_0002;
    a_req = 1'b1; b_req = 1'b1;
    n = 0; acks = 0; grants = 0; prev_ack = 1'b0;
    while (acks < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ram_en) begin
        check("cont_ram_wdata", ram_wdata, grants[0] ? 32'hBBBB_0002 : 32'hAAAA_0001);
        check("cont_ram_addr", 32'(ram_addr), grants[0] ? 32'h020 : 32'h010);
        grants++;
      end
      if (a_ack || b_ack) begin
        check("cont_gnt_b", 32'(gnt_b), 32'(acks % 2));
        check("cont_ack_1cyc", 32'(prev_ack), 32'd0);
        acks++;
        if (acks == 4) begin a_req = 1'b0; b_req = 1'b0; end
      end
      prev_ack = a_ack | b_ack;
    end
    check("cont_acks", 32'(acks), 32'd4);
    check("cont_spacing", 32'(n), 32'd11);
    @(posedge clk); #1;
    check("cont_ack_end", 32'(a_ack | b_ack), 32'd0);

    // Halt raised while A's write is in ISSUE, B waiting
    @(negedge clk);
    push_exp(1'b0, 1'b0, 32'h0);
    a_we = 1'b1; a_addr = 9'h033; a_wdata = 32'h1111_2222; a_req = 1'b1;
    @(posedge clk); #1;
    check("halt_a_issue", 32'(ram_en), 32'd1);
    halt = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0);
    b_we = 1'b1; b_addr = 9'h044; b_wdata = 32'h3333_4444; b_req = 1'b1;
    @(posedge clk); #1;
    check("halt_a_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0;
    any_ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      any_ack = any_ack | b_ack | ram_en | ~idle;
    end
    check("halt_blocked", 32'(any_ack), 32'd0);
    @(negedge clk);
    halt = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (b_ack) break;
    end
    b_req = 1'b0;
    check("halt_b_ack_cycle", 32'(n + 1), 32'd3);

    // Reset mid-read during WAIT
    @(negedge clk);
    a_we = 1'b0; a_addr = 9'h005; a_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    clr = 1'b0;
    #1;
    check("rstw_ram_en", 32'(ram_en), 32'd0);
    check("rstw_a_rdata", a_rdata, 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    any_ack = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      any_ack = any_ack | a_ack | b_ack;
    end
    check("rstw_no_ack", 32'(any_ack), 32'd0);
    check("rstw_idle", 32'(idle), 32'd1);
    check("rstw_gnt_b", 32'(gnt_b), 32'd0);

    // Reset during ISSUE drops the strobe without waiting for a clock
    @(negedge clk);
    a_we = 1'b1; a_addr = 9'h077; a_wdata = 32'h7777_7777; a_req = 1'b1;
    @(posedge clk); #1;
    check("rsti_ram_en_before", 32'(ram_en), 32'd1);
    #2;
    clr = 1'b0;
    #1;
    check("rsti_ram_en", 32'(ram_en), 32'd0);
    check("rsti_ram_we", 32'(ram_we), 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(posedge clk);

    do_txn(1'b0, 1'b0, 9'h033, 32'h0, 32'h1111_2222, 4, "a_rd_033");
    do_txn(1'b1, 1'b0, 9'h077, 32'h0, init_val(9'h077), 4, "b_rd_077");

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
    check("x_idle_end", 32'(x_idle), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
